// File: rtl/alu_stage_if.sv
// Request, ALU and response signals of the two-stage ALU wrapper.
// The slave modport is the stage's view; master is the environment's view.
interface alu_stage_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_instr;
  logic [31:0]      alu_s;
  logic             alu_ze;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_s;
  logic             out_ze;
  logic             out_ill;
  logic [TAG_W-1:0] out_tag;

  logic             zc_clr;
  logic [7:0]       zc_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_instr, in_tag,
    output in_ready,
    output alu_a, alu_b, alu_instr,
    input  alu_s, alu_ze,
    output out_valid, out_s, out_ze, out_ill, out_tag,
    input  out_ready,
    input  zc_clr,
    output zc_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_instr, in_tag,
    input  in_ready,
    input  alu_a, alu_b, alu_instr,
    output alu_s, alu_ze,
    input  out_valid, out_s, out_ze, out_ill, out_tag,
    output out_ready,
    output zc_clr,
    input  zc_cnt
  );
endinterface

// File: rtl/alu_stage.sv
// Two-stage (X, W) pipeline wrapper around an external combinational ALU,
// with illegal-op squashing and a saturating divide-by-zero counter.
module alu_stage #(
  parameter int unsigned TAG_W = 4
) (
  input logic        clk,
  input logic        rst,
  alu_stage_if.slave bus
);

  logic             x_valid_q;
  logic [31:0]      x_a_q;
  logic [31:0]      x_b_q;
  logic [31:0]      x_instr_q;
  logic [TAG_W-1:0] x_tag_q;

  logic             w_valid_q;
  logic [31:0]      w_s_q;
  logic             w_ze_q;
  logic             w_ill_q;
  logic [TAG_W-1:0] w_tag_q;

  logic [7:0]       zc_cnt_q;

  logic w_en;
  logic accept;
  logic x_ill;
  logic zc_inc;

  always_comb begin
    w_en   = !w_valid_q || bus.out_ready;
    accept = bus.in_valid && (!x_valid_q || w_en);
    x_ill  = x_instr_q[3] || (x_instr_q[2:0] == 3'b010);
    // Only a legal op actually moving X->W may count.
    zc_inc = w_en && x_valid_q && !x_ill && bus.alu_ze && (zc_cnt_q != 8'hFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_valid_q <= 1'b0;
      x_a_q     <= '0;
      x_b_q     <= '0;
      x_instr_q <= '0;
      x_tag_q   <= '0;
      w_valid_q <= 1'b0;
      w_s_q     <= '0;
      w_ze_q    <= 1'b0;
      w_ill_q   <= 1'b0;
      w_tag_q   <= '0;
      zc_cnt_q  <= '0;
    end else begin
      if (accept) begin
        x_valid_q <= 1'b1;
        x_a_q     <= bus.in_a;
        x_b_q     <= bus.in_b;
        x_instr_q <= bus.in_instr;
        x_tag_q   <= bus.in_tag;
      end else if (w_en) begin
        x_valid_q <= 1'b0;
      end

      if (w_en) begin
        w_valid_q <= x_valid_q;
        if (x_valid_q) begin
          w_tag_q <= x_tag_q;
          w_ill_q <= x_ill;
          w_s_q   <= x_ill ? 32'd0 : bus.alu_s;
          w_ze_q  <= x_ill ? 1'b0  : bus.alu_ze;
        end
      end

      if (bus.zc_clr) begin
        zc_cnt_q <= '0;
      end else if (zc_inc) begin
        zc_cnt_q <= zc_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = !x_valid_q || w_en;
  assign bus.alu_a     = x_a_q;
  assign bus.alu_b     = x_b_q;
  assign bus.alu_instr = x_instr_q;
  assign bus.out_valid = w_valid_q;
  assign bus.out_s     = w_s_q;
  assign bus.out_ze    = w_ze_q;
  assign bus.out_ill   = w_ill_q;
  assign bus.out_tag   = w_tag_q;
  assign bus.zc_cnt    = zc_cnt_q;

endmodule
